// File: rtl/uart_reg_master.sv
// -----------------------------------------------------------------------------
// uart_reg_master
//   Bus-side initiator for the UART register port. Bytes that the host offers
//   are buffered in a TX FIFO and written one at a time to the peripheral,
//   honouring per_wait. Each new received byte (a rising edge on per_r_ready)
//   triggers a single read strobe, and the byte is pushed into an RX FIFO.
//
// Ports
//   clk, rst          system clock; synchronous active-high reset
//   tx_valid/ready    host -> TX FIFO handshake, tx_data is the byte
//   rx_valid/ready    RX FIFO -> host handshake, rx_data is the head byte
//   per_we, per_di    registered write strobe and data to the peripheral
//   per_re, per_do    registered read strobe and returned data ([7:0] used)
//   per_wait          peripheral is busy transmitting the current byte
//   per_r_ready       peripheral holds a received byte (new byte on 0->1)
//   busy              FSM is not idle
//   err_timeout       sticky write-timeout flag, cleared only by rst
//   ovf_cnt           saturating count of received bytes dropped on full RX
// -----------------------------------------------------------------------------

// Synchronous FIFO with an extra wrap bit on each pointer so that full and
// empty can be told apart without a separate occupancy counter.
//   push/push_data   write one entry (caller guarantees !full)
//   pop/pop_data     pop_data is the head; pop advances it (caller: !empty)
//   full, empty      occupancy flags derived from the pointers
module uart_reg_master_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are
    // valid, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule

module uart_reg_master #(
    parameter int FIFO_DEPTH   = 8,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [7:0]  tx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [7:0]  rx_data,
    output logic        per_we,
    output logic        per_re,
    output logic [31:0] per_di,
    input  logic [31:0] per_do,
    input  logic        per_wait,
    input  logic        per_r_ready,
    output logic        busy,
    output logic        err_timeout,
    output logic [7:0]  ovf_cnt
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR_REQ,
        S_WR_BUSY
    } state_e;

    localparam int TW = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(WAIT_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [7:0]    byte_q, byte_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          rx_pending_q, rx_pending_d;
    logic          r_hist_q;
    logic          per_we_q, per_we_d;
    logic          per_re_q, per_re_d;
    logic [31:0]   per_di_q, per_di_d;
    logic          err_q, err_d;
    logic [7:0]    ovf_q, ovf_d;

    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_head;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic       rx_edge;

    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && tx_ready;
    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_valid && rx_ready;
    // The read completes at the end of the RD cycle; a full RX FIFO drops it.
    assign rx_push  = (state_q == S_RD) && !rx_full;
    assign rx_edge  = per_r_ready && !r_hist_q;

    uart_reg_master_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (tx_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    uart_reg_master_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (per_do[7:0]),
        .pop       (rx_pop),
        .pop_data  (rx_data),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    always_comb begin
        // NOTE: every signal assigned below gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        byte_d     = byte_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        ovf_d      = ovf_q;
        tx_pop     = 1'b0;

        // Set wins over clear so an edge landing during RD is not lost;
        // edges arriving while a read is already pending merge into it.
        rx_pending_d = rx_pending_q;
        if (state_q == S_RD) rx_pending_d = 1'b0;
        if (rx_edge)         rx_pending_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (rx_pending_q) begin
                    state_d = S_RD;
                end else if (!tx_empty) begin
                    state_d    = S_WR_REQ;
                    tx_pop     = 1'b1;
                    byte_d     = tx_head;
                    wait_cnt_d = '0;
                end
            end
            S_RD: begin
                state_d = S_IDLE;
                if (rx_full && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
            end
            S_WR_REQ: begin
                if (per_wait) begin
                    state_d = S_WR_BUSY;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            S_WR_BUSY: begin
                if (!per_wait) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered from the next state so they line up with
        // the state they belong to and can never overlap.
        per_we_d = (state_d == S_WR_REQ) || (state_d == S_WR_BUSY);
        per_re_d = (state_d == S_RD);
        per_di_d = per_we_d ? {24'h0, byte_d} : 32'h0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            byte_q       <= 8'h00;
            wait_cnt_q   <= '0;
            rx_pending_q <= 1'b0;
            r_hist_q     <= 1'b1;  // no false edge if per_r_ready is high at reset exit
            per_we_q     <= 1'b0;
            per_re_q     <= 1'b0;
            per_di_q     <= 32'h0;
            err_q        <= 1'b0;
            ovf_q        <= 8'h00;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            wait_cnt_q   <= wait_cnt_d;
            rx_pending_q <= rx_pending_d;
            r_hist_q     <= per_r_ready;
            per_we_q     <= per_we_d;
            per_re_q     <= per_re_d;
            per_di_q     <= per_di_d;
            err_q        <= err_d;
            ovf_q        <= ovf_d;
        end
    end

    assign per_we      = per_we_q;
    assign per_re      = per_re_q;
    assign per_di      = per_di_q;
    assign busy        = (state_q != S_IDLE);
    assign err_timeout = err_q;
    assign ovf_cnt     = ovf_q;
endmodule

// File: tb/tb_uart_reg_master.sv
// -----------------------------------------------------------------------------
// tb_uart_reg_master
//   Directed bench for uart_reg_master: write handshake and latency, TX FIFO
//   fill/ordering, write timeout, read strobes and RX data, reads deferred
//   behind a write, RX overflow counting and reset mid-write.
// -----------------------------------------------------------------------------
module tb_uart_reg_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_data;
    logic        rx_valid, rx_ready;
    logic [7:0]  rx_data;
    logic        per_we, per_re;
    logic [31:0] per_di, per_do;
    logic        per_wait, per_r_ready;
    logic        busy, err_timeout;
    logic [7:0]  ovf_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [7:0]  data;
        logic [31:0] exp_di;
    } tx_vec_t;

    typedef struct {
        logic [31:0] do_val;
        logic [7:0]  exp_rx;
    } rx_vec_t;

    tx_vec_t tx_tab [9];
    rx_vec_t rx_tab [4];

    uart_reg_master #(.FIFO_DEPTH(8), .WAIT_TIMEOUT(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .per_we      (per_we),
        .per_re      (per_re),
        .per_di      (per_di),
        .per_do      (per_do),
        .per_wait    (per_wait),
        .per_r_ready (per_r_ready),
        .busy        (busy),
        .err_timeout (err_timeout),
        .ovf_cnt     (ovf_cnt)
    );

    always #5 clk = ~clk;

    // Strobes must never overlap.
    always @(negedge clk) begin
        if (!rst && per_we && per_re) begin
            err_cnt++;
            $display("FAIL strobe_overlap: per_we=1 per_re=1 at %0t, required not both", $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_we(input int bound);
        for (int i = 0; i < bound && !per_we; i++) tick();
        check("we_wait", {31'h0, per_we}, 32'h1);
    endtask

    // Complete one write: strobe seen, data checked, one busy cycle, release.
    task automatic serve_write(input string name, input logic [31:0] exp_di);
        wait_we(20);
        check(name, per_di, exp_di);
        per_wait = 1'b1;
        tick();
        per_wait = 1'b0;
        tick();
        check({name, "_we_drop"}, {31'h0, per_we}, 32'h0);
    endtask

    // Pulse per_r_ready once and watch per_re for a few cycles.
    task automatic rx_read(input logic [31:0] do_val, output int pulses, output int first);
        per_do      = do_val;
        per_r_ready = 1'b1;
        pulses      = 0;
        first       = -1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 1) per_r_ready = 1'b0;
            if (per_re) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
    endtask

    initial begin
        int pulses;
        int first;
        int n;

        tx_tab[0] = '{8'h10, 32'h0000_0010};
        for (int i = 1; i < 9; i++) begin
            tx_tab[i].data   = 8'(8'h20 + i - 1);
            tx_tab[i].exp_di = 32'(8'h20 + i - 1);
        end
        rx_tab[0] = '{32'h0000_003C, 8'h3C};
        rx_tab[1] = '{32'hFFFF_FF81, 8'h81};
        rx_tab[2] = '{32'h1234_5600, 8'h00};
        rx_tab[3] = '{32'h0000_00FF, 8'hFF};

        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
        per_do = 32'h0; per_wait = 1'b0; per_r_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_per_we", {31'h0, per_we}, 32'h0);
        check("rst_per_re", {31'h0, per_re}, 32'h0);
        check("rst_per_di", per_di, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_tx_ready", {31'h0, tx_ready}, 32'h1);
        check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("rst_err", {31'h0, err_timeout}, 32'h0);
        check("rst_ovf", {24'h0, ovf_cnt}, 32'h0);

        // 1: single write, latency and handshake
        tx_valid = 1'b1; tx_data = 8'hA5;
        tick();
        tx_valid = 1'b0;
        check("t1_we_lat1", {31'h0, per_we}, 32'h0);
        tick();
        check("t1_we_lat2", {31'h0, per_we}, 32'h1);
        check("t1_di", per_di, 32'h0000_00A5);
        check("t1_busy", {31'h0, busy}, 32'h1);
        repeat (3) tick();
        per_wait = 1'b1;
        repeat (3) tick();
        check("t1_we_held", {31'h0, per_we}, 32'h1);
        check("t1_di_held", per_di, 32'h0000_00A5);
        per_wait = 1'b0;
        check("t1_busy_pre", {31'h0, busy}, 32'h1);
        tick();
        check("t1_we_off", {31'h0, per_we}, 32'h0);
        check("t1_busy_off", {31'h0, busy}, 32'h0);
        check("t1_di_off", per_di, 32'h0);

        // 2: write stuck busy, fill TX FIFO, drain in order
        push_tx(tx_tab[0].data);
        wait_we(10);
        per_wait = 1'b1;
        tick();
        for (int i = 1; i < 9; i++) begin
            check("t2_tx_ready", {31'h0, tx_ready}, 32'h1);
            push_tx(tx_tab[i].data);
        end
        check("t2_full", {31'h0, tx_ready}, 32'h0);
        tx_valid = 1'b1; tx_data = 8'h28;
        tick();
        tx_valid = 1'b0;
        check("t2_refused", {31'h0, tx_ready}, 32'h0);
        for (int i = 0; i < 9; i++) serve_write("t2_order", tx_tab[i].exp_di);
        repeat (5) tick();
        check("t2_no_ninth", {31'h0, per_we}, 32'h0);

        // 3: write timeout
        push_tx(8'h55);
        wait_we(10);
        check("t3_err_pre", {31'h0, err_timeout}, 32'h0);
        n = 0;
        while (per_we && n < 200) begin
            n++;
            tick();
        end
        check("t3_we_cycles", n, 32'd64);
        check("t3_err", {31'h0, err_timeout}, 32'h1);
        check("t3_idle", {31'h0, busy}, 32'h0);
        push_tx(8'h66);
        serve_write("t3_next", 32'h0000_0066);
        check("t3_err_sticky", {31'h0, err_timeout}, 32'h1);

        // 4: reads from a table
        for (int i = 0; i < 4; i++) begin
            rx_read(rx_tab[i].do_val, pulses, first);
            check("t4_re_pulses", pulses, 32'd1);
            check("t4_re_latency", first, 32'd2);
            check("t4_rx_valid", {31'h0, rx_valid}, 32'h1);
            check("t4_rx_data", {24'h0, rx_data}, {24'h0, rx_tab[i].exp_rx});
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
            check("t4_rx_popped", {31'h0, rx_valid}, 32'h0);
        end

        // 5: two edges during WR_BUSY merge into one deferred read
        push_tx(8'h77);
        wait_we(10);
        per_wait = 1'b1;
        tick();
        per_do = 32'h0000_005A;
        for (int k = 0; k < 2; k++) begin
            per_r_ready = 1'b1;
            tick();
            per_r_ready = 1'b0;
            tick();
        end
        check("t5_no_re_busy", {31'h0, per_re}, 32'h0);
        check("t5_we_busy", {31'h0, per_we}, 32'h1);
        per_wait = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (per_re) pulses++;
        end
        check("t5_one_read", pulses, 32'd1);
        check("t5_rx_data", {24'h0, rx_data}, 32'h5A);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("t5_single_entry", {31'h0, rx_valid}, 32'h0);

        // 6: RX overflow, then reset in the middle of a write
        for (int i = 0; i < 10; i++) begin
            per_do      = 32'(8'h80 + i);
            per_r_ready = 1'b1;
            tick();
            per_r_ready = 1'b0;
            repeat (3) tick();
        end
        check("t6_ovf", {24'h0, ovf_cnt}, 32'd2);
        check("t6_rx_head", {24'h0, rx_data}, 32'h80);
        check("t6_rx_valid", {31'h0, rx_valid}, 32'h1);
        push_tx(8'h99);
        wait_we(10);
        check("t6_we_pre_rst", {31'h0, per_we}, 32'h1);
        rst = 1'b1;
        tick();
        check("t6_rst_we", {31'h0, per_we}, 32'h0);
        check("t6_rst_di", per_di, 32'h0);
        check("t6_rst_busy", {31'h0, busy}, 32'h0);
        check("t6_rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("t6_rst_ovf", {24'h0, ovf_cnt}, 32'h0);
        check("t6_rst_err", {31'h0, err_timeout}, 32'h0);
        check("t6_rst_tx_ready", {31'h0, tx_ready}, 32'h1);
        rst = 1'b0;
        repeat (4) tick();
        check("t6_post_rst_idle", {31'h0, per_we}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
